pipeline_ctrl: RTL and testbench

- Stall/flush sequencer for the 5-stage datapath and its four pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Drives per-buffer enable and flush (bubble) controls plus PC enable.
- Detects load-use hazards between the instruction in ID and the load sitting in ID/EX.
- Freezes the pipeline while a multi-cycle RAM access is pending, and traps RAM timeouts.

---
 rtl/pipeline_ctrl_pkg.sv | 65 ++++++
 rtl/pipeline_ctrl_hazard_detect.sv | 30 +++
 rtl/pipeline_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM state encodings, the zero-register constant and the control bundle.
// The helper function builds the non-frozen control pattern (branch / load-use / normal).
package pipe_ctrl_pkg;

  // Default register-file address width (rs/rt/wA).
  localparam int ADDR_W_DEF = 5;

  // Sequencer states, kept as plain 2-bit constants for legacy tools.
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERR      = 2'd2;

  // Register 0 is hard-wired and never creates a dependency.
  localparam int REG_ZERO = 0;

  // All pipeline-buffer controls driven by the sequencer, as one bundle.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } ctrl_t;

  // Everything frozen, nothing flushed (RAM wait, error trap).
  localparam ctrl_t CTRL_FREEZE = '{default: 1'b0};

  // Held while reset is asserted: nothing moves, both front buffers hold bubbles.
  localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                   idex_en: 1'b0, idex_flush: 1'b1,
                                   exmem_en: 1'b0, memwb_en: 1'b0};

  // Free-running pipeline.
  localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                 idex_en: 1'b1, idex_flush: 1'b0,
                                 exmem_en: 1'b1, memwb_en: 1'b1};

  // Taken branch: everything advances, the two wrong-path slots become bubbles.
  localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                    idex_en: 1'b1, idex_flush: 1'b1,
                                    exmem_en: 1'b1, memwb_en: 1'b1};

  // Load-use: PC and IF/ID hold, a bubble goes into ID/EX while the load moves on.
  localparam ctrl_t CTRL_LU = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                idex_en: 1'b1, idex_flush: 1'b1,
                                exmem_en: 1'b1, memwb_en: 1'b1};

  // Control pattern when the RAM is not holding the pipeline: branch beats load-use,
  // since the instruction in ID is discarded by the branch anyway.
  function automatic ctrl_t ctrl_release(input logic branch_taken, input logic lu);
    ctrl_t c;
    if (branch_taken) begin
      c = CTRL_BRANCH;
    end else if (lu) begin
      c = CTRL_LU;
    end else begin
      c = CTRL_RUN;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: load in EX writing a register the ID instruction reads.
// Latency: purely combinational, same-cycle result.
// Backpressure: none; the result feeds the sequencer's stall decision.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] i_id_rs,
  input  logic [ADDR_W-1:0] i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic              i_ex_read_ram,
  input  logic              i_ex_write_br,
  input  logic [ADDR_W-1:0] i_ex_wA,
  output logic              o_lu
);

  logic is_load_wr;
  logic rs_match;
  logic rt_match;

  // Compare the load destination against both ID sources; register 0 is excluded.
  always_comb begin
    is_load_wr = i_ex_read_ram & i_ex_write_br & (i_ex_wA != ADDR_W'(REG_ZERO));
    rs_match   = (i_ex_wA == i_id_rs);
    rt_match   = i_id_uses_rt & (i_ex_wA == i_id_rt);
    o_lu       = is_load_wr & (rs_match | rt_match);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// Latency: Mealy controls, a stall/flush applies in the cycle the hazard is visible.
// Backpressure: RAM not ready freezes every buffer; timeout traps in ERR. Macro PIPE_STALL_CNT_EN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WAIT_MAX = 15          // legal range 1..255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_id_rs,
  input  logic [ADDR_W-1:0] i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic              i_ex_read_ram,
  input  logic              i_ex_write_br,
  input  logic [ADDR_W-1:0] i_ex_wA,
  input  logic              i_branch_taken,
  input  logic              i_mem_req,
  input  logic              i_ram_ready,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_ifid_flush,
  output logic              o_idex_en,
  output logic              o_idex_flush,
  output logic              o_exmem_en,
  output logic              o_memwb_en,
  output logic              o_timeout,
  output logic [15:0]       o_stall_cnt
);

  // Wait counter is 8 bits; WAIT_MAX <= 255 keeps it from wrapping.
  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  logic [1:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       lu;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;

  hazard_detect #(
    .ADDR_W(ADDR_W)
  ) u_hazard (
    .i_id_rs      (i_id_rs),
    .i_id_rt      (i_id_rt),
    .i_id_uses_rt (i_id_uses_rt),
    .i_ex_read_ram(i_ex_read_ram),
    .i_ex_write_br(i_ex_write_br),
    .i_ex_wA      (i_ex_wA),
    .o_lu         (lu)
  );

  // Next-state and Mealy control decode; a pending RAM access outranks branch and load-use.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    ctrl       = CTRL_FREEZE;
    case (state_q)
      RUN: begin
        if (i_mem_req && !i_ram_ready) begin
          // Frozen stages re-present any branch/load once the RAM releases.
          ctrl       = CTRL_FREEZE;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          ctrl = ctrl_release(i_branch_taken, lu);
        end
      end
      MEM_WAIT: begin
        if (i_ram_ready) begin
          ctrl       = ctrl_release(i_branch_taken, lu);
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          ctrl      = CTRL_FREEZE;
          state_d   = ERR;
          timeout_d = 1'b1;
        end else begin
          ctrl       = CTRL_FREEZE;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERR: begin
        // Only reset leaves the error trap.
        ctrl = CTRL_FREEZE;
      end
      default: begin
        // Unreachable encoding: recover to RUN without moving anything this cycle.
        ctrl       = CTRL_FREEZE;
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // Reset overrides the controls immediately, independent of the clock.
  always_comb begin
    ctrl_out = ctrl;
    if (!rst_n) begin
      ctrl_out = CTRL_RESET;
    end
  end

  // Sequencer state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_pc_en      = ctrl_out.pc_en;
  assign o_ifid_en    = ctrl_out.ifid_en;
  assign o_ifid_flush = ctrl_out.ifid_flush;
  assign o_idex_en    = ctrl_out.idex_en;
  assign o_idex_flush = ctrl_out.idex_flush;
  assign o_exmem_en   = ctrl_out.exmem_en;
  assign o_memwb_en   = ctrl_out.memwb_en;
  assign o_timeout    = timeout_q;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles with the PC held, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl.pc_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (WAIT_MAX 15 and 3) share stimulus,
// a cycle-level model predicts every output, plus literal spot checks.
module tb_pipeline_ctrl;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, ex_wA = '0;
  logic          id_uses_rt = 1'b0, ex_read_ram = 1'b0, ex_write_br = 1'b0;
  logic          branch_taken = 1'b0, mem_req = 1'b0, ram_ready = 1'b0;

  // Control bits ordered {pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem, memwb}
  logic [6:0]  ctl0, ctl1;
  logic        to0, to1;
  logic [15:0] sc0, sc1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.ADDR_W(AW), .WAIT_MAX(15)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_read_ram(ex_read_ram), .i_ex_write_br(ex_write_br), .i_ex_wA(ex_wA),
    .i_branch_taken(branch_taken), .i_mem_req(mem_req), .i_ram_ready(ram_ready),
    .o_pc_en(ctl0[6]), .o_ifid_en(ctl0[5]), .o_ifid_flush(ctl0[4]),
    .o_idex_en(ctl0[3]), .o_idex_flush(ctl0[2]), .o_exmem_en(ctl0[1]),
    .o_memwb_en(ctl0[0]), .o_timeout(to0), .o_stall_cnt(sc0)
  );

  pipeline_ctrl #(.ADDR_W(AW), .WAIT_MAX(3)) u_dut_to (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_read_ram(ex_read_ram), .i_ex_write_br(ex_write_br), .i_ex_wA(ex_wA),
    .i_branch_taken(branch_taken), .i_mem_req(mem_req), .i_ram_ready(ram_ready),
    .o_pc_en(ctl1[6]), .o_ifid_en(ctl1[5]), .o_ifid_flush(ctl1[4]),
    .o_idex_en(ctl1[3]), .o_idex_flush(ctl1[2]), .o_exmem_en(ctl1[1]),
    .o_memwb_en(ctl1[0]), .o_timeout(to1), .o_stall_cnt(sc1)
  );

  localparam logic [6:0] P_RESET  = 7'b0010100;
  localparam logic [6:0] P_FROZEN = 7'b0000000;
  localparam logic [6:0] P_NORMAL = 7'b1101011;
  localparam logic [6:0] P_BRANCH = 7'b1111111;
  localparam logic [6:0] P_LU     = 7'b0001111;

  // ---------------- behavioural model ----------------
  bit m_wait[2];     // RAM access outstanding
  bit m_err[2];      // trapped after timeout
  int m_waited[2];   // unready cycles seen for the outstanding access
  bit m_to[2];
  int m_stall[2];

  function automatic int wmax(input int k);
    return (k == 0) ? 15 : 3;
  endfunction

  function automatic bit lu_now();
    return ex_read_ram && ex_write_br && (ex_wA != 0) &&
           ((ex_wA == id_rs) || (id_uses_rt && (ex_wA == id_rt)));
  endfunction

  function automatic logic [6:0] exp_ctl(input int k);
    if (!rst_n) return P_RESET;
    if (m_err[k]) return P_FROZEN;
    if (m_wait[k] ? !ram_ready : (mem_req && !ram_ready)) return P_FROZEN;
    if (branch_taken) return P_BRANCH;
    if (lu_now()) return P_LU;
    return P_NORMAL;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_wait[k] = 0; m_err[k] = 0; m_waited[k] = 0; m_to[k] = 0; m_stall[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [6:0] e;
        e = exp_ctl(k);
        if (!e[6] && m_stall[k] < 65535) m_stall[k] = m_stall[k] + 1;
        if (!m_err[k] && (m_wait[k] || (mem_req && !ram_ready))) begin
          if (m_wait[k] && ram_ready) begin
            m_wait[k] = 0;
            m_waited[k] = 0;
          end else begin
            m_wait[k] = 1;
            m_waited[k] = m_waited[k] + 1;
            if (m_waited[k] > wmax(k)) begin
              m_err[k] = 1;
              m_to[k] = 1;
            end
          end
        end
      end
    end
  end

  function automatic int exp_stall(input int k);
`ifdef PIPE_STALL_CNT_EN
    return m_stall[k];
`else
    return 0;
`endif
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("ctl0", int'(ctl0), int'(exp_ctl(0)));
    chk("ctl1", int'(ctl1), int'(exp_ctl(1)));
    chk("timeout0", int'(to0), int'(m_to[0]));
    chk("timeout1", int'(to1), int'(m_to[1]));
    chk("stall0", int'(sc0), exp_stall(0));
    chk("stall1", int'(sc1), exp_stall(1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_wA = '0; id_uses_rt = 0;
    ex_read_ram = 0; ex_write_br = 0; branch_taken = 0; mem_req = 0; ram_ready = 0;
  endtask

  localparam int SAT_STALL = 16'hFFFF;

  initial begin
    fork
      forever begin
        @(negedge clk);
        cmp_all();
      end
    join_none

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("lit_reset_ctl", int'(ctl0), int'(P_RESET));
    chk("lit_reset_to", int'(to0), 0);
    chk("lit_reset_sc", int'(sc0), 0);
    rst_n = 1;
    @(negedge clk);
    chk("lit_run_ctl", int'(ctl0), int'(P_NORMAL));

    // Load-use on rs: exactly one bubble, then the load has moved on
    tick();
    ex_read_ram = 1; ex_write_br = 1; ex_wA = 3; id_rs = 3;
    @(negedge clk);
    chk("lit_lu_rs", int'(ctl0), int'(P_LU));
    tick();
    ex_read_ram = 0; ex_write_br = 0; ex_wA = 0;
    @(negedge clk);
    chk("lit_lu_after", int'(ctl0), int'(P_NORMAL));

    // Destination register 0 never stalls
    tick();
    ex_read_ram = 1; ex_write_br = 1; ex_wA = 0; id_rs = 0;
    @(negedge clk);
    chk("lit_lu_r0", int'(ctl0), int'(P_NORMAL));

    // rt match only counts when rt is used
    tick();
    ex_wA = 3; id_rs = 1; id_rt = 3; id_uses_rt = 0;
    @(negedge clk);
    chk("lit_lu_rt_unused", int'(ctl0), int'(P_NORMAL));
    tick();
    id_uses_rt = 1;
    @(negedge clk);
    chk("lit_lu_rt_used", int'(ctl0), int'(P_LU));
    tick();
    ex_write_br = 0;
    @(negedge clk);
    chk("lit_lu_no_wr", int'(ctl0), int'(P_NORMAL));

    // Branch beats load-use
    tick();
    ex_write_br = 1; branch_taken = 1;
    @(negedge clk);
    chk("lit_branch_lu", int'(ctl0), int'(P_BRANCH));
    tick();
    clear_inputs();

    // RAM wait: 4 unready cycles then ready, counter starts from a fresh reset
    rst_n = 0;
    tick();
    rst_n = 1; mem_req = 1; ram_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_ram_frozen", int'(ctl0), int'(P_FROZEN));
      tick();
    end
    ram_ready = 1;
    @(negedge clk);
    chk("lit_ram_release", int'(ctl0), int'(P_NORMAL));
    tick();
    clear_inputs();
    @(negedge clk);
    chk("lit_ram_run", int'(ctl0), int'(P_NORMAL));
`ifdef PIPE_STALL_CNT_EN
    chk("lit_ram_stall4", int'(sc0), 4);
`else
    chk("lit_ram_stall0", int'(sc0), 0);
`endif

    // Reset asserted mid-MEM_WAIT (5 wait cycles) acts within the cycle
    tick();
    mem_req = 1;
    for (int i = 0; i < 5; i++) tick();
    mem_req = 0;
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("lit_async_rst_ctl", int'(ctl0), int'(P_RESET));
    chk("lit_async_rst_to", int'(to0), 0);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("lit_after_rst", int'(ctl0), int'(P_NORMAL));

    // Timeout on the WAIT_MAX=3 instance
    tick();
    mem_req = 1; ram_ready = 0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("lit_to_before", int'(to1), 0);
    tick();
    @(negedge clk);
    chk("lit_to_rise", int'(to1), 1);
    tick();
    ram_ready = 1;
    tick(); tick();
    @(negedge clk);
    chk("lit_to_sticky", int'(to1), 1);
    chk("lit_to_frozen", int'(ctl1), int'(P_FROZEN));

    // Long stall for saturation
    ram_ready = 0;
    for (int i = 0; i < 70000; i++) tick();
    @(negedge clk);
`ifdef PIPE_STALL_CNT_EN
    chk("lit_sat0", int'(sc0), SAT_STALL);
    chk("lit_sat1", int'(sc1), SAT_STALL);
`else
    chk("lit_nocnt0", int'(sc0), 0);
    chk("lit_nocnt1", int'(sc1), 0);
`endif
    chk("lit_err0_to", int'(to0), 1);

    // Reset pulse clears the trap
    tick();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("lit_clear_to1", int'(to1), 0);
    chk("lit_clear_ctl1", int'(ctl1), int'(P_NORMAL));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
